// File: rtl/slime_pkg.sv
// Shared slime-game types: motion states, update sequencer states, collision bit indices and
// the screen bounds used by the player, display and level blocks.
package slime_pkg;

  typedef enum logic [1:0] {
    MotionGround = 2'd0,
    MotionRise   = 2'd1,
    MotionFall   = 2'd2
  } motion_e;

  typedef enum logic [1:0] {
    SeqIdle,
    SeqHoriz,
    SeqVert,
    SeqCommit
  } seq_e;

  localparam int unsigned COL_BOTTOM = 0;
  localparam int unsigned COL_LEFT   = 1;
  localparam int unsigned COL_TOP    = 2;
  localparam int unsigned COL_RIGHT  = 3;

  localparam logic [9:0] SCREEN_X_MIN  = 10'd144;
  localparam logic [9:0] SCREEN_X_MAX  = 10'd752;  // 783 - sprite width + 1
  localparam logic [9:0] SCREEN_Y_MIN  = 10'd66;   // 35 + sprite height - 1
  localparam logic [9:0] SCREEN_Y_MAX  = 10'd514;  // floor row
  localparam logic [9:0] PLAYER_X_INIT = 10'd144;
  localparam logic [9:0] PLAYER_Y_INIT = 10'd514;

  // Sign-extend a 6-bit velocity to the 12-bit position arithmetic width.
  function automatic logic signed [11:0] sext_vel(input logic [5:0] v);
    return {{6{v[5]}}, v};
  endfunction

endpackage

// File: rtl/player_controller_if.sv
// Frame/button/collision inputs and position/motion outputs of the player controller.
// master: the side issuing frameStart and inputs; slave: player_controller.
interface player_controller_if;
  logic        frameStart;
  logic        btnL;
  logic        btnR;
  logic        btnU;
  logic [3:0]  playerCol;
  logic [19:0] playerPos;
  logic [1:0]  motionState;
  logic [5:0]  velY;
  logic        busy;

  modport master (
    output frameStart, btnL, btnR, btnU, playerCol,
    input  playerPos, motionState, velY, busy
  );

  modport slave (
    input  frameStart, btnL, btnR, btnU, playerCol,
    output playerPos, motionState, velY, busy
  );
endinterface

// File: rtl/player_jump_fsm.sv
// GROUND/RISE/FALL motion state and vertical velocity. Optional airborne jump is built only
// when PLAYER_DOUBLE_JUMP_EN is defined. Inputs are stable from capture until commitEn.
module player_jump_fsm
  import slime_pkg::*;
#(
  parameter logic [5:0] JUMP_VEL = 6'd12,
  parameter logic [5:0] GRAVITY  = 6'd1,
  parameter logic [5:0] MAX_FALL = 6'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       commitEn,
  input  logic       jumpEdge,
  input  logic [3:0] col,
  input  logic       hitFloor,
  input  logic       hitCeil,
  output logic       moveY,
  output motion_e    motionState,
  output logic [5:0] velY
);

  localparam logic signed [5:0] JumpVy  = -$signed(JUMP_VEL);
  localparam logic signed [5:0] GravVy  = $signed(GRAVITY);
  localparam logic signed [5:0] MaxFall = $signed(MAX_FALL);

  motion_e           stateQ, stateD;
  logic signed [5:0] vyQ, vyD, vyStep;
  logic              dblJump;

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic allowQ;

  // Airborne-jump allowance: spent by an air jump, restored whenever we land
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      allowQ <= 1'b1;
    end else if (commitEn) begin
      if (stateD == MotionGround) allowQ <= 1'b1;
      else if (dblJump)           allowQ <= 1'b0;
    end
  end

  assign dblJump = allowQ & jumpEdge & ~col[COL_TOP] & (stateQ != MotionGround);
`else
  assign dblJump = 1'b0;
`endif

  // Next motion state and velocity for this frame
  always_comb begin
    stateD = stateQ;
    vyD    = vyQ;
    moveY  = 1'b0;
    vyStep = '0;
    unique case (stateQ)
      MotionGround: begin
        vyD = '0;
        if (jumpEdge && col[COL_BOTTOM]) begin
          stateD = MotionRise;
          vyD    = JumpVy;
        end else if (!col[COL_BOTTOM]) begin
          stateD = MotionFall;
        end
      end
      MotionRise: begin
        if (dblJump) begin
          vyD = JumpVy;
        end else if (col[COL_TOP]) begin
          stateD = MotionFall;
          vyD    = '0;
        end else begin
          moveY  = 1'b1;
          vyStep = vyQ + GravVy;
          if (hitCeil) begin
            stateD = MotionFall;
            vyD    = '0;
          end else begin
            vyD = vyStep;
            if (!vyStep[5]) stateD = MotionFall;
          end
        end
      end
      MotionFall: begin
        if (col[COL_BOTTOM]) begin
          stateD = MotionGround;
          vyD    = '0;
        end else if (dblJump) begin
          stateD = MotionRise;
          vyD    = JumpVy;
        end else begin
          moveY  = 1'b1;
          vyStep = vyQ + GravVy;
          if (vyStep > MaxFall) vyStep = MaxFall;
          if (hitFloor) begin
            stateD = MotionGround;
            vyD    = '0;
          end else begin
            vyD = vyStep;
          end
        end
      end
      default: begin
        stateD = MotionGround;
        vyD    = '0;
      end
    endcase
  end

  // Motion state and velocity publish together with the position commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= MotionGround;
      vyQ    <= '0;
    end else if (commitEn) begin
      stateQ <= stateD;
      vyQ    <= vyD;
    end
  end

  assign motionState = stateQ;
  assign velY        = vyQ;

endmodule

// File: rtl/player_controller.sv
// Per-frame player motion engine: IDLE->HORIZ->VERT->COMMIT sequencer, horizontal walk and
// screen clamping. Define PLAYER_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_controller
  import slime_pkg::*;
#(
  parameter logic [9:0] X_INIT     = PLAYER_X_INIT,
  parameter logic [9:0] Y_INIT     = PLAYER_Y_INIT,
  parameter logic [9:0] X_MIN      = SCREEN_X_MIN,
  parameter logic [9:0] X_MAX      = SCREEN_X_MAX,
  parameter logic [9:0] Y_MIN      = SCREEN_Y_MIN,
  parameter logic [9:0] Y_MAX      = SCREEN_Y_MAX,
  parameter logic [3:0] WALK_SPEED = 4'd2,
  parameter logic [5:0] JUMP_VEL   = 6'd12,
  parameter logic [5:0] GRAVITY    = 6'd1,
  parameter logic [5:0] MAX_FALL   = 6'd8
) (
  input logic                clk,
  input logic                rst,
  player_controller_if.slave bus
);

  seq_e              seqQ, seqD;
  logic              start;
  logic              btnLQ, btnRQ, btnUQ, btnUPrevQ;
  logic [3:0]        colQ;
  logic [9:0]        xPosQ, yPosQ, xWorkQ, yWorkQ, xNext, yNext, xLeft;
  logic [10:0]       xWide, xRight, xLeftLimit;
  logic              moveL, moveR;
  logic signed [11:0] ySum;
  logic              moveY, hitFloor, hitCeil;
  motion_e           motion;
  logic [5:0]        velY;

  // frameStart arriving while busy is dropped
  assign start = bus.frameStart && (seqQ == SeqIdle);

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seqQ <= SeqIdle;
    else     seqQ <= seqD;
  end

  // Sequencer next state: one fixed pass per accepted frame
  always_comb begin
    seqD = seqQ;
    unique case (seqQ)
      SeqIdle:   if (bus.frameStart) seqD = SeqHoriz;
      SeqHoriz:  seqD = SeqVert;
      SeqVert:   seqD = SeqCommit;
      SeqCommit: seqD = SeqIdle;
      default:   seqD = SeqIdle;
    endcase
  end

  // Shadow capture of inputs; btnUPrevQ keeps the previous frame's btnU for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnLQ     <= 1'b0;
      btnRQ     <= 1'b0;
      btnUQ     <= 1'b0;
      btnUPrevQ <= 1'b0;
      colQ      <= '0;
    end else if (start) begin
      btnLQ     <= bus.btnL;
      btnRQ     <= bus.btnR;
      btnUPrevQ <= btnUQ;
      btnUQ     <= bus.btnU;
      colQ      <= bus.playerCol;
    end
  end

  assign moveL      = btnLQ & ~btnRQ & ~colQ[COL_LEFT];
  assign moveR      = btnRQ & ~btnLQ & ~colQ[COL_RIGHT];
  assign xWide      = {1'b0, xPosQ};
  assign xRight     = xWide + 11'(WALK_SPEED);
  assign xLeft      = xPosQ - 10'(WALK_SPEED);
  assign xLeftLimit = {1'b0, X_MIN} + 11'(WALK_SPEED);

  // Horizontal walk with saturation; the limit compare also covers underflow below zero
  always_comb begin
    xNext = xPosQ;
    if (moveL)      xNext = (xWide < xLeftLimit) ? X_MIN : xLeft;
    else if (moveR) xNext = (xRight > {1'b0, X_MAX}) ? X_MAX : xRight[9:0];
  end

  assign ySum     = $signed({2'b00, yPosQ}) + (moveY ? sext_vel(velY) : 12'sd0);
  assign hitFloor = moveY && (ySum >= $signed({2'b00, Y_MAX}));
  assign hitCeil  = moveY && (ySum <= $signed({2'b00, Y_MIN}));

  // Vertical position clamp
  always_comb begin
    yNext = ySum[9:0];
    if (hitFloor)     yNext = Y_MAX;
    else if (hitCeil) yNext = Y_MIN;
  end

  // Stage results into work registers, published together at COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xWorkQ <= X_INIT;
      yWorkQ <= Y_INIT;
      xPosQ  <= X_INIT;
      yPosQ  <= Y_INIT;
    end else begin
      case (seqQ)
        SeqHoriz:  xWorkQ <= xNext;
        SeqVert:   yWorkQ <= yNext;
        SeqCommit: begin
          xPosQ <= xWorkQ;
          yPosQ <= yWorkQ;
        end
        default: ;
      endcase
    end
  end

  player_jump_fsm #(
    .JUMP_VEL (JUMP_VEL),
    .GRAVITY  (GRAVITY),
    .MAX_FALL (MAX_FALL)
  ) u_jump (
    .clk         (clk),
    .rst         (rst),
    .commitEn    (seqQ == SeqCommit),
    .jumpEdge    (btnUQ & ~btnUPrevQ),
    .col         (colQ),
    .hitFloor    (hitFloor),
    .hitCeil     (hitCeil),
    .moveY       (moveY),
    .motionState (motion),
    .velY        (velY)
  );

  assign bus.playerPos   = {xPosQ, yPosQ};
  assign bus.motionState = motion;
  assign bus.velY        = velY;
  assign bus.busy        = (seqQ != SeqIdle);

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: frame-level reference model of walk, jump and gravity rules.
module tb_player_controller;

`ifdef PLAYER_DOUBLE_JUMP_EN
  localparam bit DjEn = 1'b1;
`else
  localparam bit DjEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_controller_if bus ();
  player_controller_if bus2 ();

  assign bus2.frameStart = bus.frameStart;
  assign bus2.btnL       = bus.btnL;
  assign bus2.btnR       = bus.btnR;
  assign bus2.btnU       = bus.btnU;
  assign bus2.playerCol  = bus.playerCol;

  player_controller u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance starting one pixel right of the left bound
  player_controller #(
    .X_INIT (10'd145)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state (plain integers, frame granularity)
  int mx, my, ms, mvy;
  bit mprevU, mallow;

  task automatic model_reset();
    mx = 144; my = 514; ms = 0; mvy = 0; mprevU = 1'b0; mallow = 1'b1;
  endtask

  task automatic model_frame(input bit l, input bit r, input bit u, input bit [3:0] col);
    bit edgeU, dj;
    edgeU  = u && !mprevU;
    mprevU = u;
    if (l && !r && !col[1])      mx = (mx - 2 < 144) ? 144 : mx - 2;
    else if (r && !l && !col[3]) mx = (mx + 2 > 752) ? 752 : mx + 2;
    dj = DjEn && (ms != 0) && mallow && edgeU && !col[2];
    case (ms)
      0: begin
        if (edgeU && col[0]) begin ms = 1; mvy = -12; end
        else begin mvy = 0; if (!col[0]) ms = 2; end
      end
      1: begin
        if (dj) begin mvy = -12; mallow = 1'b0; end
        else if (col[2]) begin ms = 2; mvy = 0; end
        else begin
          my = my + mvy;
          if (my <= 66) begin my = 66; ms = 2; mvy = 0; end
          else begin mvy = mvy + 1; if (mvy >= 0) ms = 2; end
        end
      end
      default: begin
        if (col[0]) begin ms = 0; mvy = 0; end
        else if (dj) begin ms = 1; mvy = -12; mallow = 1'b0; end
        else begin
          my = my + mvy;
          if (my >= 514) begin my = 514; ms = 0; mvy = 0; end
          else mvy = (mvy + 1 > 8) ? 8 : mvy + 1;
        end
      end
    endcase
    if (ms == 0) mallow = 1'b1;
  endtask

  function automatic logic [19:0] exp_pos();
    return {10'(mx), 10'(my)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.frameStart = 1'b0; bus.btnL = 1'b0; bus.btnR = 1'b0; bus.btnU = 1'b0;
    bus.playerCol = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One accepted frame; returns at the first negedge with busy low
  task automatic run_frame(input bit l, input bit r, input bit u, input bit [3:0] col);
    @(negedge clk);
    bus.btnL = l; bus.btnR = r; bus.btnU = u; bus.playerCol = col;
    bus.frameStart = 1'b1;
    @(negedge clk);
    bus.frameStart = 1'b0;
    model_frame(l, r, u, col);
    for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
    if (bus.busy !== 1'b0) begin
      testsRun++; testsFailed++;
      $display("FAIL frame_timeout: busy=%b after 20 cycles, required 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    testsRun++;
    if (bus.playerPos !== {10'd144, 10'd514} || bus.motionState !== 2'd0 ||
        bus.velY !== 6'd0 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_state: pos=%h st=%0d vy=%h busy=%b, required pos=%h st=0 vy=0 busy=0",
               bus.playerPos, bus.motionState, bus.velY, bus.busy, {10'd144, 10'd514});
    end
    testsRun++;
    if (bus2.playerPos !== {10'd145, 10'd514}) begin
      testsFailed++;
      $display("FAIL reset_xinit: pos=%h required %h", bus2.playerPos, {10'd145, 10'd514});
    end
    run_frame(1'b0, 1'b0, 1'b0, 4'b0001);
    testsRun++;
    if (bus.playerPos !== {10'd144, 10'd514} || bus.motionState !== 2'd0 || bus.velY !== 6'd0) begin
      testsFailed++;
      $display("FAIL idle_frame: pos=%h st=%0d vy=%h, required pos=%h st=0 vy=0",
               bus.playerPos, bus.motionState, bus.velY, {10'd144, 10'd514});
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b0, 1'b1, 1'b0, 4'b0001);
      testsRun++;
      if (bus.playerPos !== exp_pos()) begin
        testsFailed++;
        $display("FAIL walk_right[%0d]: pos=%h required %h", i, bus.playerPos, exp_pos());
      end
    end
    testsRun++;
    if (bus.playerPos[19:10] !== 10'd150) begin
      testsFailed++;
      $display("FAIL walk_x150: x=%0d required 150", bus.playerPos[19:10]);
    end
    run_frame(1'b0, 1'b1, 1'b0, 4'b1001);
    testsRun++;
    if (bus.playerPos[19:10] !== 10'd150) begin
      testsFailed++;
      $display("FAIL walk_blocked_right: x=%0d required 150", bus.playerPos[19:10]);
    end
  endtask

  task automatic test_jump();
    logic [9:0] yHold;
    run_frame(1'b0, 1'b0, 1'b0, 4'b0001);
    run_frame(1'b0, 1'b0, 1'b1, 4'b0001);
    testsRun++;
    if (bus.motionState !== 2'd1 || bus.velY !== 6'h34) begin
      testsFailed++;
      $display("FAIL jump_start: st=%0d vy=%0d, required st=1 vy=-12",
               bus.motionState, $signed(bus.velY));
    end
    run_frame(1'b0, 1'b0, 1'b1, 4'b0000);
    testsRun++;
    if (bus.playerPos[9:0] !== 10'd502 || bus.velY !== 6'h35 || bus.motionState !== 2'd1) begin
      testsFailed++;
      $display("FAIL jump_first_rise: y=%0d vy=%0d st=%0d, required y=502 vy=-11 st=1",
               bus.playerPos[9:0], $signed(bus.velY), bus.motionState);
    end
    for (int i = 0; i < 4; i++) run_frame(1'b0, 1'b0, 1'b1, 4'b0000);
    yHold = bus.playerPos[9:0];
    run_frame(1'b0, 1'b0, 1'b1, 4'b0100);
    testsRun++;
    if (bus.motionState !== 2'd2 || bus.velY !== 6'd0 || bus.playerPos[9:0] !== yHold) begin
      testsFailed++;
      $display("FAIL jump_ceiling: st=%0d vy=%0d y=%0d, required st=2 vy=0 y=%0d",
               bus.motionState, $signed(bus.velY), bus.playerPos[9:0], yHold);
    end
    for (int i = 0; i < 10; i++) begin
      run_frame(1'b0, 1'b0, 1'b0, 4'b0000);
      testsRun++;
      if (bus.playerPos !== exp_pos() || bus.velY !== 6'(mvy) || bus.motionState !== 2'(ms)) begin
        testsFailed++;
        $display("FAIL fall[%0d]: pos=%h vy=%0d st=%0d, required pos=%h vy=%0d st=%0d", i,
                 bus.playerPos, $signed(bus.velY), bus.motionState, exp_pos(), mvy, ms);
      end
    end
    testsRun++;
    if (bus.velY !== 6'd8) begin
      testsFailed++;
      $display("FAIL fall_terminal: vy=%0d required 8", $signed(bus.velY));
    end
    run_frame(1'b0, 1'b0, 1'b0, 4'b0001);
    testsRun++;
    if (bus.motionState !== 2'd0 || bus.velY !== 6'd0 || bus.playerPos !== exp_pos()) begin
      testsFailed++;
      $display("FAIL land: st=%0d vy=%0d pos=%h, required st=0 vy=0 pos=%h",
               bus.motionState, $signed(bus.velY), bus.playerPos, exp_pos());
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] oldPos;
    do_reset();
    oldPos = bus.playerPos;
    @(negedge clk);
    bus.btnL = 1'b0; bus.btnR = 1'b1; bus.btnU = 1'b0; bus.playerCol = 4'b0001;
    bus.frameStart = 1'b1;
    model_frame(1'b0, 1'b1, 1'b0, 4'b0001);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.frameStart = (c == 2);  // stray pulse while busy
      testsRun++;
      if (bus.busy !== 1'b1 || bus.playerPos !== oldPos) begin
        testsFailed++;
        $display("FAIL busy_cycle%0d: busy=%b pos=%h, required busy=1 pos=%h",
                 c, bus.busy, bus.playerPos, oldPos);
      end
    end
    @(negedge clk);
    bus.frameStart = 1'b0;
    testsRun++;
    if (bus.busy !== 1'b0 || bus.playerPos !== exp_pos()) begin
      testsFailed++;
      $display("FAIL commit_cycle4: busy=%b pos=%h, required busy=0 pos=%h",
               bus.busy, bus.playerPos, exp_pos());
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      testsRun++;
      if (bus.busy !== 1'b0 || bus.playerPos !== exp_pos()) begin
        testsFailed++;
        $display("FAIL single_commit[%0d]: busy=%b pos=%h, required busy=0 pos=%h",
                 c, bus.busy, bus.playerPos, exp_pos());
      end
    end
  endtask

  task automatic test_left_clamp();
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0, 4'b0001);
    testsRun++;
    if (bus.playerPos[19:10] !== 10'd144 || bus2.playerPos[19:10] !== 10'd144) begin
      testsFailed++;
      $display("FAIL left_clamp: x=%0d x2=%0d, required 144 and 144",
               bus.playerPos[19:10], bus2.playerPos[19:10]);
    end
    run_frame(1'b0, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 2; i++) begin
      run_frame(1'b1, 1'b0, 1'b0, 4'b0001);
      testsRun++;
      if (bus.playerPos !== exp_pos()) begin
        testsFailed++;
        $display("FAIL walk_left[%0d]: pos=%h required %h", i, bus.playerPos, exp_pos());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_frame(1'b0, 1'b1, 1'b0, 4'b0001);
    @(negedge clk);
    bus.btnR = 1'b1; bus.frameStart = 1'b1;
    @(negedge clk);
    bus.frameStart = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    testsRun++;
    if (bus.playerPos !== exp_pos() || bus.busy !== 1'b0 || bus.motionState !== 2'd0) begin
      testsFailed++;
      $display("FAIL reset_mid: pos=%h busy=%b st=%0d, required pos=%h busy=0 st=0",
               bus.playerPos, bus.busy, bus.motionState, exp_pos());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    testsRun++;
    if (bus.playerPos !== exp_pos() || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_no_partial: pos=%h busy=%b, required pos=%h busy=0",
               bus.playerPos, bus.busy, exp_pos());
    end
  endtask

  task automatic test_double_jump();
    bit       uSeq [7] = '{1, 1, 1, 0, 1, 0, 1};
    bit [3:0] cSeq [7] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_frame(1'b0, 1'b0, uSeq[i], cSeq[i]);
      testsRun++;
      if (bus.playerPos !== exp_pos() || bus.velY !== 6'(mvy) || bus.motionState !== 2'(ms)) begin
        testsFailed++;
        $display("FAIL dj_frame[%0d]: pos=%h vy=%0d st=%0d, required pos=%h vy=%0d st=%0d", i,
                 bus.playerPos, $signed(bus.velY), bus.motionState, exp_pos(), mvy, ms);
      end
      if (i == 4) begin
        testsRun++;
        if (bus.motionState !== (DjEn ? 2'd1 : 2'd2) || bus.velY !== (DjEn ? 6'h34 : 6'd1)) begin
          testsFailed++;
          $display("FAIL dj_second_edge: st=%0d vy=%0d, required st=%0d vy=%0d",
                   bus.motionState, $signed(bus.velY), DjEn ? 1 : 2, DjEn ? -12 : 1);
        end
      end
      if (i == 6) begin
        testsRun++;
        if (bus.motionState !== (DjEn ? 2'd1 : 2'd2) || bus.velY !== (DjEn ? 6'h36 : 6'd3)) begin
          testsFailed++;
          $display("FAIL dj_third_edge: st=%0d vy=%0d, required st=%0d vy=%0d",
                   bus.motionState, $signed(bus.velY), DjEn ? 1 : 2, DjEn ? -10 : 3);
        end
      end
    end
  endtask

  task automatic test_random();
    bit l, r, u;
    bit [3:0] col;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      l   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      u   = 1'($urandom_range(0, 1));
      col = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(l, r, u, col);
      testsRun++;
      if (bus.playerPos !== exp_pos() || bus.velY !== 6'(mvy) || bus.motionState !== 2'(ms)) begin
        testsFailed++;
        $display("FAIL random[%0d]: pos=%h vy=%0d st=%0d, required pos=%h vy=%0d st=%0d", i,
                 bus.playerPos, $signed(bus.velY), bus.motionState, exp_pos(), mvy, ms);
      end
    end
  endtask

  initial begin
    bus.frameStart = 1'b0; bus.btnL = 1'b0; bus.btnR = 1'b0; bus.btnU = 1'b0;
    bus.playerCol = 4'b0000;
    model_reset();
    test_reset();
    test_walk();
    test_jump();
    test_back_to_back();
    test_left_clamp();
    test_reset_mid();
    test_double_jump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/player_controller.md
# player_controller

Per-frame player motion engine that produces the 20-bit `playerPos` consumed by the display controller. It sits directly upstream of the display controller. On each `frameStart` pulse it:
- samples the movement buttons and the 4-bit collision flags;
- runs a short multi-cycle update of horizontal walk, jump/gravity and screen clamping;
- publishes the new position well before the next frame.

The display controller latches `playerPos` at `frameStart`, so each update appears on screen one frame later.

## Interface
Parameters:
- `X_INIT`, 10'd144: reset X (left edge of sprite)
- `Y_INIT`, 10'd514: reset Y (bottom row of sprite; sprite spans Y-31..Y)
- `X_MIN`, 10'd144: smallest legal X
- `X_MAX`, 10'd752: largest legal X (783-31)
- `Y_MIN`, 10'd66: smallest legal Y (35+31)
- `Y_MAX`, 10'd514: largest legal Y (floor)
- `WALK_SPEED`, 4'd2: pixels per frame horizontally
- `JUMP_VEL`, 6'd12: initial upward speed, pixels per frame
- `GRAVITY`, 6'd1: velocity increment per frame
- `MAX_FALL`, 6'd8: terminal downward speed

Ports:
- `clk`  in  1: system clock (same domain as display controller)
- `rst`  in  1: asynchronous, active-high reset
- `frameStart`  in  1: one-cycle pulse at start of frame
- `btnL`, `btnR`, `btnU`  in  1 each: synchronized, debounced level inputs
- `playerCol`  in  4: collision flags, valid on the `frameStart` cycle. Bit 0 = bottom, 1 = left, 2 = top, 3 = right
- `playerPos`  out  20: {X[19:10], Y[9:0]}, registered
- `motionState`  out  2: GROUND=0, RISE=1, FALL=2
- `velY`  out  6: signed vertical velocity, positive = downward
- `busy`  out  1: high while an update is in progress

## Operation
- **Update sequencer:** IDLE → HORIZ → VERT → COMMIT → IDLE.
  - Leaves IDLE only on `frameStart`.
  - Buttons and `playerCol` are captured into shadow registers on that cycle.
  - All later stages use only the captured values.
- **HORIZ:**
  - `btnL & ~btnR & ~col[1]`: X − `WALK_SPEED`.
  - `btnR & ~btnL & ~col[3]`: X + `WALK_SPEED`.
  - Both buttons or neither: no move.
  - Saturate to [`X_MIN`, `X_MAX`]; never wrap. Use 11-bit intermediate arithmetic.
- **VERT (motion FSM):**
  - GROUND:
    - Rising edge of `btnU` versus the previous frame's capture, with `col[0]` set → RISE, vy = −`JUMP_VEL`.
    - Otherwise, if `col[0]` is clear → FALL, vy = 0.
  - RISE:
    - `col[2]` set → FALL, vy = 0, Y unchanged.
    - Otherwise Y += vy, then vy += `GRAVITY`; vy ≥ 0 → FALL.
  - FALL:
    - `col[0]` set → GROUND, vy = 0, Y unchanged.
    - Otherwise Y += vy, then vy = min(vy + `GRAVITY`, `MAX_FALL`).
  - Y saturates to [`Y_MIN`, `Y_MAX`].
    - Reaching `Y_MAX` forces GROUND, vy = 0.
    - Reaching `Y_MIN` while rising forces FALL, vy = 0.
- **COMMIT:** write X/Y into `playerPos`; `motionState` and `velY` update in the same cycle.
- `frameStart` while `busy` is ignored. It cannot occur with legal VGA timing, but the bench must still check it.
- Reset values:
  - `playerPos` = {`X_INIT`, `Y_INIT`}
  - `motionState` = GROUND
  - `velY` = 0
  - `busy` = 0
  - Sequencer in IDLE; button-history register = 0.
- Reset mid-update abandons the update; no partial commit.

## Timing
- `frameStart` at cycle 0.
- `busy` is high in cycles 1–3.
- `playerPos`, `motionState` and `velY` change at the end of cycle 3 and are visible at cycle 4.
- `busy` is low from cycle 4.
- One update per frame at most. Display latency is one frame.
- The jump edge is frame-granular: holding `btnU` yields exactly one jump.

## Configuration
- `PLAYER_DOUBLE_JUMP_EN` defined:
  - One extra jump is permitted while in RISE or FALL, on a `btnU` edge with `col[2]` clear.
  - The jump resets vy = −`JUMP_VEL` and enters RISE.
  - The allowance is restored on entry to GROUND and on reset.
- Undefined: `btnU` is ignored outside GROUND, and the allowance register is not built.

## Structure
- Shared package `slime_pkg`:
  - motion-state encodings
  - collision bit indices (`COL_BOTTOM`, `COL_LEFT`, `COL_TOP`, `COL_RIGHT`)
  - screen-bound constants shared with the display controller and the level block
- Sub-module `player_jump_fsm`: the GROUND/RISE/FALL state, vy arithmetic and the double-jump allowance. The top level holds the sequencer, horizontal path and clamping.

## Test plan
- Reset → `playerPos` = {144, 514}, GROUND, `velY` = 0; one frame with no buttons and `col` = 4'b0001 → unchanged.
- `btnR` held for 3 frames with `col` = 0001 → X = 150. Then `btnR` with `col[3]` = 1 → X stays 150.
- `btnU` rising edge with `col` = 0001 → RISE, `velY` = −12. The next committed Y is 502, with `velY` = −11.
- RISE with `col[2]` = 1 → FALL, `velY` = 0, Y unchanged. Subsequent frames with `col` = 0: `velY` goes 1, 2, …, saturates at 8. `col[0]` = 1 → GROUND, `velY` = 0.
- `btnL` at X = 145 → X = 144 (saturate, no wrap). A second `frameStart` during `busy` → ignored, exactly one commit.
- With `PLAYER_DOUBLE_JUMP_EN`: second `btnU` edge in FALL → RISE, `velY` = −12; a third edge before landing → no effect. Without the macro, the second edge has no effect.
